// File: rtl/pci_cmp_pkg.sv
// ============================================================================
// Module  : pci_cmp_pkg
// Brief   : Shared types and constants for the PCI request completer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pci_cmp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        ACCESS  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pci_req_completer_if.sv
// ============================================================================
// Module  : pci_req_completer_if
// Brief   : Bridge-to-completer PCI request/response bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pci_req_completer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import pci_cmp_pkg::*;

    logic              PCI_REQ;
    logic              PCI_WR;
    logic [ADDR_W-1:0] PCI_ADDR;
    logic [DATA_W-1:0] PCI_WDATA;
    logic              PCI_GNT;
    logic              PCI_READY;
    logic [DATA_W-1:0] PCI_RDATA;
    logic              PCI_ERR;
    logic [CNT_W-1:0]  WR_CNT;
    logic [CNT_W-1:0]  RD_CNT;

    modport master (
        output PCI_REQ, PCI_WR, PCI_ADDR, PCI_WDATA,
        input  PCI_GNT, PCI_READY, PCI_RDATA, PCI_ERR, WR_CNT, RD_CNT
    );

    modport slave (
        input  PCI_REQ, PCI_WR, PCI_ADDR, PCI_WDATA,
        output PCI_GNT, PCI_READY, PCI_RDATA, PCI_ERR, WR_CNT, RD_CNT
    );

endinterface

`default_nettype wire

// File: rtl/pci_cmp_regfile.sv
// ============================================================================
// Module  : pci_cmp_regfile
// Brief   : Word storage for the completer window; sync write, comb read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_cmp_regfile #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  wire logic              HCLK,
    input  wire logic              HRESETn,
    input  wire logic              we_i,
    input  wire logic [IDX_W-1:0]  idx_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_word
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                mem_q[i] <= '0;
            end else if (we_i && (idx_i == IDX_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/pci_req_completer.sv
// ============================================================================
// Module  : pci_req_completer
// Brief   : Modelled PCI target: grant/access latency, decoded word window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_req_completer
    import pci_cmp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int                GNT_LAT   = 2,
    parameter int                ACC_LAT   = 3
) (
    input wire logic         HCLK,
    input wire logic         HRESETn,
    pci_req_completer_if.slave bus
);

    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int LAT_MAX = (GNT_LAT > ACC_LAT) ? GNT_LAT : ACC_LAT;
    localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [LAT_W-1:0]  GNT_LOAD  = LAT_W'(GNT_LAT - 1);
    localparam logic [LAT_W-1:0]  ACC_LOAD  = LAT_W'(ACC_LAT - 1);
    localparam logic [ADDR_W:0]   WIN_BYTES = (ADDR_W + 1)'(MEM_DEPTH * 4);

    state_e            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt_q;
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;

    logic [CNT_W-1:0]  wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_d;
    logic [ADDR_W-1:0] off_w;
    logic              err_w;
    logic [IDX_W-1:0]  idx_w;
    logic              we_w;
    logic [DATA_W-1:0] mem_rdata_w;

    // Decode works only from the captured address, never the live bus.
    assign off_w = addr_q - BASE_ADDR;
    assign err_w = ({1'b0, off_w} >= WIN_BYTES) || (addr_q[1:0] != 2'b00);
    assign idx_w = off_w[IDX_W+1:2];
    assign we_w  = (state_q == DONE) && wr_q && !err_q;

    assign wr_cnt_d = sat_inc(wr_cnt_q);
    assign rd_cnt_d = sat_inc(rd_cnt_q);

    pci_cmp_regfile #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we_i    (we_w),
        .idx_i   (idx_w),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_w)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.PCI_REQ) begin
                        wr_q    <= bus.PCI_WR;
                        addr_q  <= bus.PCI_ADDR;
                        wdata_q <= bus.PCI_WDATA;
                        cnt_q   <= GNT_LOAD;
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (!bus.PCI_REQ) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        gnt_q   <= 1'b1;
                        cnt_q   <= ACC_LOAD;
                        state_q <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACCESS: begin
                    if (!bus.PCI_REQ) begin
                        gnt_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        // Response is registered on entry so it is valid for the whole DONE cycle.
                        ready_q <= 1'b1;
                        err_q   <= err_w;
                        if (wr_q) begin
                            rdata_q <= '0;
                        end else if (err_w) begin
                            rdata_q <= DATA_W'(ERR_RDATA);
                        end else begin
                            rdata_q <= mem_rdata_w;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    gnt_q   <= 1'b0;
                    if (!err_q) begin
                        if (wr_q) begin
                            wr_cnt_q <= wr_cnt_d;
                        end else begin
                            rd_cnt_q <= rd_cnt_d;
                        end
                    end
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.PCI_GNT   = gnt_q;
    assign bus.PCI_READY = ready_q;
    assign bus.PCI_ERR   = err_q;
    assign bus.PCI_RDATA = rdata_q;
    assign bus.WR_CNT    = wr_cnt_q;
    assign bus.RD_CNT    = rd_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pci_req_completer.sv
// ============================================================================
// Module  : tb_pci_req_completer
// Brief   : Directed self-checking bench for the PCI request completer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pci_req_completer;

    logic HCLK;
    logic HRESETn;

    int checks = 0;
    int errors = 0;
    int wr_exp = 0;
    int rd_exp = 0;

    pci_req_completer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pci_req_completer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (16),
        .BASE_ADDR (32'h0000_0000),
        .GNT_LAT   (2),
        .ACC_LAT   (3)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_wr_cnt"}, 32'(bus.WR_CNT), 32'(wr_exp));
        chk({tag, "_rd_cnt"}, 32'(bus.RD_CNT), 32'(rd_exp));
    endtask

    // Entered with REQ already driven; the next edge is the sampling edge N.
    task automatic expect_txn(input string tag, input logic exp_err,
                              input logic [31:0] exp_rdata, input logic keep_req);
        tick();                                     // N
        chk({tag, "_gnt_n0"}, 32'(bus.PCI_GNT), 32'd0);
        tick();                                     // N+1
        chk({tag, "_gnt_n1"}, 32'(bus.PCI_GNT), 32'd0);
        tick();                                     // N+2
        chk({tag, "_gnt_rise"}, 32'(bus.PCI_GNT), 32'd1);
        chk({tag, "_rdy_early"}, 32'(bus.PCI_READY), 32'd0);
        tick();
        tick();                                     // N+4
        chk({tag, "_rdy_pre"}, 32'(bus.PCI_READY), 32'd0);
        chk({tag, "_rdata_idle"}, bus.PCI_RDATA, 32'd0);
        tick();                                     // N+5
        chk({tag, "_rdy"}, 32'(bus.PCI_READY), 32'd1);
        chk({tag, "_gnt_done"}, 32'(bus.PCI_GNT), 32'd1);
        chk({tag, "_err"}, 32'(bus.PCI_ERR), 32'(exp_err));
        chk({tag, "_rdata"}, bus.PCI_RDATA, exp_rdata);
        if (!keep_req) bus.PCI_REQ = 1'b0;
        tick();                                     // N+6, RELEASE
        chk({tag, "_rdy_off"}, 32'(bus.PCI_READY), 32'd0);
        chk({tag, "_gnt_rel"}, 32'(bus.PCI_GNT), 32'd0);
        chk({tag, "_err_off"}, 32'(bus.PCI_ERR), 32'd0);
        chk({tag, "_rdata_off"}, bus.PCI_RDATA, 32'd0);
        tick();                                     // N+7, back in IDLE
        chk({tag, "_gnt_idle"}, 32'(bus.PCI_GNT), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata);
        bus.PCI_REQ   = 1'b1;
        bus.PCI_WR    = wr;
        bus.PCI_ADDR  = addr;
        bus.PCI_WDATA = wdata;
        expect_txn(tag, exp_err, exp_rdata, 1'b0);
    endtask

    initial begin
        bus.PCI_REQ   = 1'b0;
        bus.PCI_WR    = 1'b0;
        bus.PCI_ADDR  = '0;
        bus.PCI_WDATA = '0;
        HRESETn       = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.PCI_GNT), 32'd0);
        chk("rst_ready", 32'(bus.PCI_READY), 32'd0);
        chk("rst_err", 32'(bus.PCI_ERR), 32'd0);
        chk("rst_rdata", bus.PCI_RDATA, 32'd0);
        chk_cnt("rst");
        HRESETn = 1'b1;
        tick();

        // Basic write then readback
        run_txn("wr8", 1'b1, 32'h0000_0008, 32'hA5A5_1234, 1'b0, 32'h0);
        wr_exp = 1;
        chk_cnt("wr8");
        run_txn("rd8", 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'hA5A5_1234);
        rd_exp = 1;
        chk_cnt("rd8");

        // Out-of-window read
        run_txn("rd40", 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk_cnt("rd40");

        // Misaligned write is dropped
        run_txn("wr6", 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b1, 32'h0);
        chk_cnt("wr6");
        run_txn("rd4", 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0);
        rd_exp = 2;
        chk_cnt("rd4");

        // Abort: REQ dropped the cycle after GNT rises
        bus.PCI_REQ   = 1'b1;
        bus.PCI_WR    = 1'b1;
        bus.PCI_ADDR  = 32'h0000_0008;
        bus.PCI_WDATA = 32'h1111_1111;
        tick();
        tick();
        tick();
        chk("abt_gnt_rise", 32'(bus.PCI_GNT), 32'd1);
        bus.PCI_REQ = 1'b0;
        tick();
        chk("abt_gnt_fall", 32'(bus.PCI_GNT), 32'd0);
        chk("abt_rdy0", 32'(bus.PCI_READY), 32'd0);
        tick();
        tick();
        chk("abt_rdy1", 32'(bus.PCI_READY), 32'd0);
        chk("abt_gnt_low", 32'(bus.PCI_GNT), 32'd0);
        run_txn("abt_rd8", 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'hA5A5_1234);
        rd_exp = 3;
        chk_cnt("abt");

        // Reset asserted during ACCESS of a write to 0x4
        bus.PCI_REQ   = 1'b1;
        bus.PCI_WR    = 1'b1;
        bus.PCI_ADDR  = 32'h0000_0004;
        bus.PCI_WDATA = 32'hCAFE_0001;
        tick();
        tick();
        tick();
        tick();
        chk("mrst_gnt_pre", 32'(bus.PCI_GNT), 32'd1);
        HRESETn = 1'b0;
        #1;
        wr_exp = 0;
        rd_exp = 0;
        chk("mrst_gnt", 32'(bus.PCI_GNT), 32'd0);
        chk("mrst_ready", 32'(bus.PCI_READY), 32'd0);
        chk("mrst_rdata", bus.PCI_RDATA, 32'd0);
        chk_cnt("mrst");
        bus.PCI_REQ = 1'b0;
        tick();
        HRESETn = 1'b1;
        run_txn("mrst_rd4", 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0);
        rd_exp = 1;
        run_txn("mrst_rd8", 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0);
        rd_exp = 2;
        chk_cnt("mrst_after");

        // Back-to-back: REQ held through READY; second request reuses the line
        bus.PCI_REQ   = 1'b1;
        bus.PCI_WR    = 1'b1;
        bus.PCI_ADDR  = 32'h0000_0010;
        bus.PCI_WDATA = 32'h0000_00AA;
        expect_txn("b2b_wr", 1'b0, 32'h0, 1'b1);
        bus.PCI_WR    = 1'b0;
        bus.PCI_WDATA = 32'h0;
        expect_txn("b2b_rd", 1'b0, 32'h0000_00AA, 1'b0);
        wr_exp = 1;
        rd_exp = 3;
        chk_cnt("b2b");

        // Saturation: preload the write counter just below the limit
        force dut.wr_cnt_q = 16'hFFFE;
        tick();
        release dut.wr_cnt_q;
        tick();
        wr_exp = 32'hFFFE;
        chk_cnt("sat_pre");
        run_txn("sat_wr1", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0);
        wr_exp = 32'hFFFF;
        chk_cnt("sat_wr1");
        run_txn("sat_wr2", 1'b1, 32'h0000_0000, 32'h0000_0002, 1'b0, 32'h0);
        chk_cnt("sat_wr2");
        run_txn("sat_rd0", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0002);
        rd_exp = 4;
        chk_cnt("sat_rd0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
